// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity selection, receiver state
// encoding and the bit-vote helper.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Two-out-of-three vote used to decide each received bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped and
// reported on o_overrun.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_overrun,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_empty;
  logic             w_full;
  logic             w_doPop;
  logic             w_doPush;

  assign w_empty   = (r_wrPtr == r_rdPtr);
  assign w_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPop   = i_pop & ~w_empty;
  assign w_doPush  = i_push & (~w_full | w_doPop);
  assign o_overrun = i_push & w_full & ~w_doPop;
  assign o_valid   = ~w_empty;
  assign o_count   = r_wrPtr - r_rdPtr;
  assign o_data    = r_mem[r_rdPtr[AW-1:0]];

  // Read/write pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronizes the line, votes each bit at
// mid-bit, checks parity and stop bits, flags breaks and queues each frame
// with its error flags into a small FWFT FIFO.
module uart_rx_cfg import uart_pkg::*; #(
  parameter int           CLK_FREQ_HZ = 40_000_000,
  parameter int           BAUD        = 46080,
  parameter int           DATA_BITS   = 8,
  parameter parity_mode_t PARITY      = NONE,
  parameter int           STOP_BITS   = 1,
  parameter int           FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          rx_data_o,
  output logic                          rx_parity_err_o,
  output logic                          rx_frame_err_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          overrun_o,
  output logic                          break_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int BIT_CNT = CLK_FREQ_HZ / BAUD;
  localparam int CW      = $clog2(BIT_CNT);
  localparam int FW      = DATA_BITS + 2;

  localparam logic [CW-1:0] C_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(BIT_CNT / 2);
  localparam logic [CW-1:0] C_VOTE = CW'(BIT_CNT / 2 + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [3:0]    BI_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    BI_LAST_STOP = 4'(STOP_BITS - 1);

  if (BIT_CNT < 8) begin : g_chkBitCnt
    $error("uart_rx_cfg: CLK_FREQ_HZ/BAUD must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chkDataBits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chkDepth
    $error("uart_rx_cfg: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chkStop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  logic                          r_sync1;
  logic                          r_sync2;
  rx_state_t                     r_state;
  logic [CW-1:0]                 r_cnt;
  logic [3:0]                    r_bitIdx;
  logic [DATA_BITS-1:0]          r_shift;
  logic                          r_samp0;
  logic                          r_samp1;
  logic                          r_parErr;
  logic                          r_frameErr;
  logic                          r_anyOne;

  logic                          w_rxs;
  logic                          w_vote;
  logic                          w_atVote;
  logic                          w_wrap;
  logic                          w_push;
  logic                          w_break;
  logic [FW-1:0]                 w_fifoIn;
  logic [FW-1:0]                 w_head;
  logic                          w_fifoValid;
  logic                          w_fifoOverrun;
  logic [$clog2(FIFO_DEPTH):0]   w_fifoCount;

  assign w_rxs    = r_sync2;
  assign w_vote   = majority3(r_samp0, r_samp1, w_rxs);
  assign w_atVote = (r_cnt == C_VOTE);
  assign w_wrap   = (r_cnt == C_LAST);
  assign w_push   = (r_state == ST_STOP) && w_atVote && (r_bitIdx == BI_LAST_STOP);
  assign w_break  = w_push & ~r_anyOne & ~w_vote;
  assign w_fifoIn = {r_frameErr | ~w_vote, r_parErr, r_shift};

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // Bit timing, sampling and frame state machine.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_samp0    <= 1'b0;
      r_samp1    <= 1'b0;
      r_parErr   <= 1'b0;
      r_frameErr <= 1'b0;
      r_anyOne   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || r_state == ST_WAIT_IDLE || w_wrap) r_cnt <= '0;
      else r_cnt <= r_cnt + C_ONE;
      if (r_cnt == C_S0) r_samp0 <= w_rxs;
      if (r_cnt == C_S1) r_samp1 <= w_rxs;

      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            r_state    <= ST_START;
            r_bitIdx   <= '0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
            r_anyOne   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_atVote && w_vote) r_state <= ST_IDLE;
          else if (w_wrap)        r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_atVote) begin
            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (w_vote) r_anyOne <= 1'b1;
          end
          if (w_wrap) begin
            if (r_bitIdx == BI_LAST_DATA) begin
              r_bitIdx <= '0;
              r_state  <= (PARITY == NONE) ? ST_STOP : ST_PARITY;
            end else begin
              r_bitIdx <= r_bitIdx + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_atVote) begin
            r_parErr <= ((^r_shift) ^ w_vote) != (PARITY == ODD);
            if (w_vote) r_anyOne <= 1'b1;
          end
          if (w_wrap) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_atVote) begin
            if (!w_vote) r_frameErr <= 1'b1;
            else         r_anyOne   <= 1'b1;
            if (r_bitIdx == BI_LAST_STOP) r_state <= w_rxs ? ST_IDLE : ST_WAIT_IDLE;
          end else if (w_wrap) begin
            r_bitIdx <= r_bitIdx + 4'd1;
          end
        end
        ST_WAIT_IDLE: begin
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_data    (w_fifoIn),
    .i_pop     (rx_ready_i),
    .o_data    (w_head),
    .o_valid   (w_fifoValid),
    .o_overrun (w_fifoOverrun),
    .o_count   (w_fifoCount)
  );

  assign rx_valid_o      = reset_n & w_fifoValid;
  assign rx_data_o       = rx_valid_o ? w_head[DATA_BITS-1:0] : '0;
  assign rx_parity_err_o = rx_valid_o & w_head[DATA_BITS];
  assign rx_frame_err_o  = rx_valid_o & w_head[DATA_BITS+1];
  assign overrun_o       = reset_n & w_fifoOverrun;
  assign break_o         = reset_n & w_break;
  assign busy_o          = reset_n & (r_state != ST_IDLE);
  assign fifo_count_o    = reset_n ? w_fifoCount : '0;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: one default-configured receiver at 868 clocks/bit
// and one fast even-parity receiver at 16 clocks/bit.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BIT_A = 868;
  localparam int BIT_B = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rxA, readyA, parA, frmA, validA, ovA, brkA, busyA;
  logic [7:0] dataA;
  logic [2:0] cntA;
  logic       rxB, readyB, parB, frmB, validB, ovB, brkB, busyB;
  logic [7:0] dataB;
  logic [2:0] cntB;

  int total = 0;
  int bad = 0;
  int ovCntA = 0, brkCntA = 0, ovCntB = 0, brkCntB = 0;
  int expOvB = 0, expBrkB = 0;
  logic [9:0] q[$];

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  uart_rx_cfg dutA (
    .clk(clk), .reset_n(reset_n), .rx_i(rxA), .rx_data_o(dataA),
    .rx_parity_err_o(parA), .rx_frame_err_o(frmA), .rx_valid_o(validA),
    .rx_ready_i(readyA), .overrun_o(ovA), .break_o(brkA), .busy_o(busyA),
    .fifo_count_o(cntA)
  );

  uart_rx_cfg #(
    .CLK_FREQ_HZ(40_000_000), .BAUD(2_500_000), .PARITY(EVEN)
  ) dutB (
    .clk(clk), .reset_n(reset_n), .rx_i(rxB), .rx_data_o(dataB),
    .rx_parity_err_o(parB), .rx_frame_err_o(frmB), .rx_valid_o(validB),
    .rx_ready_i(readyB), .overrun_o(ovB), .break_o(brkB), .busy_o(busyB),
    .fifo_count_o(cntB)
  );

  // Count the cycles in which each pulse output is high.
  always @(posedge clk) begin
    if (ovA)  ovCntA++;
    if (brkA) brkCntA++;
    if (ovB)  ovCntB++;
    if (brkB) brkCntB++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive nbits of a frame (LSB first) onto one line, one bit per bit time.
  task automatic applyStimulus(input bit onA, input logic [11:0] bits, input int nbits);
    int bitClk;
    bitClk = onA ? BIT_A : BIT_B;
    for (int i = 0; i < nbits; i++) begin
      if (onA) rxA = bits[i];
      else     rxB = bits[i];
      repeat (bitClk) @(negedge clk);
    end
    if (onA) rxA = 1'b1;
    else     rxB = 1'b1;
  endtask

  // One even-parity frame on line B followed by one idle bit time.
  task automatic sendB(input logic [7:0] d, input logic p, input logic s);
    applyStimulus(1'b0, {1'b1, s, p, d, 1'b0}, 11);
    waitCycles(BIT_B);
  endtask

  // Reference: what receiver B should queue for a frame, plus pulse bookkeeping.
  task automatic modelFrameB(input logic [7:0] d, input logic p, input logic s);
    logic [9:0] entry;
    entry = {~s, ^{d, p}, d};
    if (q.size() < 4) q.push_back(entry);
    else expOvB++;
    if (d == 8'h00 && !p && !s) expBrkB++;
  endtask

  task automatic popCheckB(input string name, input logic [9:0] exp);
    checkOutput({name, " valid"}, validB, 1);
    checkOutput(name, {frmB, parB, dataB}, exp);
    readyB = 1'b1;
    @(negedge clk);
    readyB = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h03, 1'b1, 1'b1, {2'b01, 8'h03}};
    vecs[1] = '{8'h03, 1'b0, 1'b1, {2'b00, 8'h03}};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, {2'b00, 8'hFF}};
    vecs[3] = '{8'h80, 1'b0, 1'b1, {2'b01, 8'h80}};
    vecs[4] = '{8'h80, 1'b1, 1'b1, {2'b00, 8'h80}};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, {2'b10, 8'h5A}};
    vecs[6] = '{8'h7E, 1'b1, 1'b0, {2'b11, 8'h7E}};

    reset_n = 1'b0;
    rxA = 1'b1; rxB = 1'b1; readyA = 1'b0; readyB = 1'b0;
    waitCycles(3);
    checkOutput("reset validA", validA, 0);
    checkOutput("reset busyA", busyA, 0);
    checkOutput("reset countA", cntA, 0);
    checkOutput("reset dataA", {frmA, parA, dataA}, 0);
    checkOutput("reset pulsesA", {ovA, brkA}, 0);
    checkOutput("reset validB", validB, 0);
    checkOutput("reset countB", cntB, 0);
    reset_n = 1'b1;
    waitCycles(4);
    checkOutput("idle busyA", busyA, 0);

    // Clean 0xA5 frame at default rate.
    applyStimulus(1'b1, {3'b111, 8'hA5, 1'b0}, 10);
    waitCycles(4);
    checkOutput("A5 count", cntA, 1);
    checkOutput("A5 valid", validA, 1);
    checkOutput("A5 entry", {frmA, parA, dataA}, {2'b00, 8'hA5});
    checkOutput("A5 busy", busyA, 0);
    readyA = 1'b1; @(negedge clk); readyA = 1'b0;
    checkOutput("A5 count after pop", cntA, 0);

    // 400-cycle glitch is shorter than half a bit: false start.
    rxA = 1'b0;
    waitCycles(200);
    checkOutput("glitch busy", busyA, 1);
    waitCycles(200);
    rxA = 1'b1;
    waitCycles(2 * BIT_A);
    checkOutput("glitch busy end", busyA, 0);
    checkOutput("glitch valid", validA, 0);
    checkOutput("glitch count", cntA, 0);
    checkOutput("glitch pulses", {ovCntA[15:0], brkCntA[15:0]}, 0);

    // Table of single even-parity frames on B.
    for (int i = 0; i < 7; i++) begin
      sendB(vecs[i].data, vecs[i].pbit, vecs[i].stop);
      checkOutput($sformatf("vec%0d count", i), cntB, 1);
      popCheckB($sformatf("vec%0d entry", i), vecs[i].exp);
      checkOutput($sformatf("vec%0d count after pop", i), cntB, 0);
    end

    // Line low for 12 bit times: break.
    rxB = 1'b0;
    waitCycles(12 * BIT_B);
    checkOutput("break wait_idle busy", busyB, 1);
    checkOutput("break count", cntB, 1);
    checkOutput("break pulses", brkCntB, 1);
    rxB = 1'b1;
    waitCycles(4);
    checkOutput("break busy end", busyB, 0);
    popCheckB("break entry", {2'b10, 8'h00});
    expBrkB = 1;
    checkOutput("break single pulse", brkCntB, expBrkB);

    // Five frames into a depth-4 FIFO with no consumer.
    for (int d = 1; d <= 5; d++) begin
      logic [7:0] b;
      b = 8'(d);
      sendB(b, ^b, 1'b1);
      checkOutput($sformatf("ovr count f%0d", d), cntB, (d > 4) ? 4 : d);
      checkOutput($sformatf("ovr pulses f%0d", d), ovCntB, (d == 5) ? 1 : 0);
    end
    expOvB = 1;
    for (int d = 1; d <= 4; d++) popCheckB($sformatf("ovr pop%0d", d), {2'b00, 8'(d)});
    checkOutput("ovr drained", cntB, 0);

    // Reset in the middle of data bit 3, then a clean 0x5A.
    sendB(8'h11, 1'b0, 1'b1);
    checkOutput("pre-reset count", cntB, 1);
    applyStimulus(1'b0, 12'b0000_0000_0110, 4);
    rxB = 1'b0;
    waitCycles(8);
    checkOutput("mid-frame busy", busyB, 1);
    reset_n = 1'b0;
    waitCycles(3);
    checkOutput("mid reset count", cntB, 0);
    checkOutput("mid reset busy", busyB, 0);
    checkOutput("mid reset valid", validB, 0);
    reset_n = 1'b1;
    rxB = 1'b1;
    waitCycles(3 * BIT_B);
    checkOutput("post reset busy", busyB, 0);
    checkOutput("post reset count", cntB, 0);
    sendB(8'h5A, 1'b0, 1'b1);
    checkOutput("5A count", cntB, 1);
    popCheckB("5A entry", {2'b00, 8'h5A});
    checkOutput("5A drained", cntB, 0);

    // Randomized frames against the queue model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic p, s;
      if (i % 8 == 7) begin
        d = 8'h00; p = 1'b0; s = 1'b0;
      end else begin
        d = 8'($urandom_range(0, 255));
        p = (^d) ^ ($urandom_range(0, 3) == 0);
        s = ($urandom_range(0, 5) != 0);
      end
      modelFrameB(d, p, s);
      sendB(d, p, s);
      checkOutput($sformatf("rand%0d count", i), cntB, q.size());
      checkOutput($sformatf("rand%0d overruns", i), ovCntB, expOvB);
      checkOutput($sformatf("rand%0d breaks", i), brkCntB, expBrkB);
      if (q.size() > 0 && $urandom_range(0, 2) == 0)
        popCheckB($sformatf("rand%0d pop", i), q.pop_front());
    end
    while (q.size() > 0) popCheckB("rand drain", q.pop_front());
    checkOutput("rand final count", cntB, 0);
    checkOutput("rand final valid", validB, 0);
    checkOutput("A pulses end", {ovCntA[15:0], brkCntA[15:0]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 40_000_000, input clock frequency.
REQ-002 SHALL have parameter BAUD, default 46080, line rate; BIT_CNT = CLK_FREQ_HZ/BAUD (integer division, 868 at defaults).
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..9.
REQ-004 SHALL have parameter PARITY, default NONE, one of NONE/ODD/EVEN.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two, at least 2.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port rx_i, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data_o, output, DATA_BITS, FIFO head data.
REQ-011 SHALL have port rx_parity_err_o, output, 1, FIFO head parity-error flag.
REQ-012 SHALL have port rx_frame_err_o, output, 1, FIFO head framing-error flag.
REQ-013 SHALL have port rx_valid_o, output, 1, FIFO not empty.
REQ-014 SHALL have port rx_ready_i, input, 1, consumer accept.
REQ-015 SHALL have port overrun_o, output, 1, one-cycle pulse when a frame is dropped.
REQ-016 SHALL have port break_o, output, 1, one-cycle pulse on break detection.
REQ-017 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-018 SHALL have port fifo_count_o, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.

Function
REQ-019 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; a bit counter counts 0..BIT_CNT-1, then wraps.
REQ-021 SHALL in IDLE move to START on rxs==0 with the counter cleared.
REQ-022 SHALL sample each bit by majority vote of rxs at counts BIT_CNT/2-1, BIT_CNT/2, BIT_CNT/2+1.
REQ-023 SHALL in START return to IDLE (false start, nothing pushed) when the voted start bit is 1; otherwise go to DATA at counter wrap.
REQ-024 SHALL in DATA capture DATA_BITS bits LSB first, then go to PARITY if PARITY!=NONE, else to STOP.
REQ-025 SHALL set the parity error when the XOR of the data bits and the parity bit is not 1 for ODD, or not 0 for EVEN.
REQ-026 SHALL in STOP set the frame error if any voted stop bit is 0; decision is at the last stop bit's vote (BIT_CNT/2+1), not at bit end.
REQ-027 SHALL at that decision cycle push {frame_err, parity_err, data} into the FIFO, then go to IDLE if rxs==1, else to WAIT_IDLE.
REQ-028 SHALL hold WAIT_IDLE until rxs==1, then go to IDLE.
REQ-029 SHALL pulse break_o when all data bits, the parity bit (if present) and the stop bit(s) vote 0; the frame is still pushed with the frame error set.
REQ-030 SHALL on a push while the FIFO is full and rx_ready_i low drop the frame and pulse overrun_o in the push cycle; FIFO contents are unchanged.
REQ-031 SHALL on a push while full with rx_valid_o&rx_ready_i pop and push in the same cycle, with no overrun.
REQ-032 SHALL make the FIFO first-word-fall-through; pop occurs on rx_valid_o&rx_ready_i; rx_valid_o rises the cycle after a push into an empty FIFO.
REQ-033 SHALL update fifo_count_o the cycle after each push/pop; simultaneous push and pop leaves it unchanged.
REQ-034 SHALL ignore rx_ready_i while rx_valid_o is low.

Reset
REQ-035 SHALL on reset_n==0 at a clock edge enter IDLE and clear the counters, shift register, error flags and FIFO pointers; both synchronizer flops are set to 1.
REQ-036 SHALL hold rx_valid_o, overrun_o, break_o, busy_o, fifo_count_o and all data/flag outputs at 0 during reset.
REQ-037 SHALL on reset mid-frame discard the partial frame; reception resumes only from a new falling edge after reset release.

Structure
REQ-038 SHALL take parity_mode_t (NONE/ODD/EVEN) and the rx state enum from shared package uart_pkg.
REQ-039 SHALL implement the FIFO as sub-module uart_rx_fifo (parameters WIDTH, DEPTH).
REQ-040 SHALL fail elaboration if BIT_CNT<8, DATA_BITS is outside 5..9, or FIFO_DEPTH is not a power of two.

Verification
REQ-041 SHALL cover: defaults, frame 0xA5 at 868 clk/bit -> one entry, data 0xA5, both error flags 0, rx_valid_o high.
REQ-042 SHALL cover: PARITY=EVEN, data 0x03 sent with parity bit 1 -> data 0x03, rx_parity_err_o=1; parity bit 0 -> rx_parity_err_o=0.
REQ-043 SHALL cover: 400-cycle low glitch on an idle line -> nothing pushed, busy_o returns to 0, no error flags.
REQ-044 SHALL cover: line low for 12 bit times -> one entry, data 0x00, frame error 1, break_o single pulse, WAIT_IDLE until line high.
REQ-045 SHALL cover: rx_ready_i=0, FIFO_DEPTH=4, 5 frames 0x01..0x05 -> fifo_count_o=4, overrun_o pulse on the 5th, pops return 0x01..0x04.
REQ-046 SHALL cover: reset_n low during data bit 3, then a clean 0x5A -> only 0x5A is received.
